mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Parametrised burst memory controller: the next generation of the MMU-side external memory model.
- Collects write beats into a full line and commits the line to an internal line-wide array with byte masks.
- Serves read bursts at any byte offset, fetching two consecutive lines when a burst crosses a line boundary.
- Returns read beats on a valid/ready channel with backpressure; sits between the MMU external port and backing storage.

Parameters:
- BEAT_WIDTH, 128, bits per data beat; multiple of 8.
- BEATS, 4, beats per line; power of 2, at least 2.
- DEPTH, 16, lines in the array; power of 2.
- PADDR_WIDTH, 32, physical address width.
- Derived: LINE_BYTES = BEATS*BEAT_WIDTH/8; OFS_W = log2(LINE_BYTES); IDX_W = log2(DEPTH); LEN_W = log2(BEATS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_vld  in  1  request valid
- o_req_rdy  out  1  controller idle, accepts request
- i_req_wr  in  1  1 = write, 0 = read
- i_req_paddr  in  PADDR_WIDTH  byte address
- i_req_len  in  LEN_W  beats minus 1
- i_wdat_vld  in  1  write beat valid
- o_wdat_rdy  out  1  write beat accepted
- i_wdat  in  BEAT_WIDTH  write beat
- i_wmask  in  BEAT_WIDTH/8  byte enables for write beat
- o_wr_ack  out  1  one-cycle write-complete pulse
- o_rdat_vld  out  1  read beat valid
- i_rdat_rdy  in  1  read beat consumed
- o_rdat  out  BEAT_WIDTH  read beat
- o_rdat_last  out  1  final beat of burst
- o_busy  out  1  not IDLE

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: o_req_rdy=1; all other outputs 0; state IDLE; beat counter 0. Array contents are not reset.
- Reset asserted mid-burst aborts the burst: no ack, no further beats, no partial array write. Beats already committed stay in the array.
- Request handshake: the request is taken when i_req_vld & o_req_rdy. o_req_rdy = (state==IDLE).
- Request fields are registered on acceptance. Later changes to request inputs are ignored.
- Line index: idx = paddr[OFS_W+IDX_W-1:OFS_W]. Upper address bits are ignored (address aliasing). Line idx+1 wraps modulo DEPTH.
- States: IDLE, WCOL, WCOMMIT, RD0, RD1, RRESP.
- Write path:
  - IDLE -> WCOL on an accepted write.
  - Writes are line-aligned: paddr[OFS_W-1:0] is ignored and treated as 0.
  - In WCOL, o_wdat_rdy=1. Each i_wdat_vld stores beat k (k = 0..len) into staging slot k with its mask, then increments the counter.
  - Staging slots above len carry mask 0.
  - After beat len is taken: WCOL -> WCOMMIT.
  - WCOMMIT: one-cycle masked line write to array[idx]; o_wr_ack=1 in this cycle; -> IDLE.
  - Latency: the ack arrives 1 cycle after the last beat handshake.
  - Staging masks clear on every new write request.
- Read path:
  - IDLE -> RD0 on an accepted read.
  - The array has a 1-cycle synchronous read. RD0 issues a read of line idx.
  - cross = (ofs + (len+1)*BEAT_WIDTH/8 > LINE_BYTES).
  - If cross: RD0 -> RD1, which issues a read of line idx+1 (wrapped). The line returned by RD0 is held in a line register.
  - Then -> RRESP.
  - RRESP forms {line1, line0} (line1 = 0 when not cross) and shifts it right by ofs*8 bits. Beat k = bits [k*BEAT_WIDTH +: BEAT_WIDTH] of the shifted value.
  - o_rdat_vld=1 throughout RRESP. o_rdat and o_rdat_last stay stable while ~i_rdat_rdy.
  - The counter advances on vld&rdy. o_rdat_last=1 on beat len.
  - The last-beat handshake -> IDLE.
  - First beat valid: 2 cycles after acceptance, or 3 if cross.
- Read-after-write: a read accepted in the cycle after WCOMMIT returns the new data. No bypass is needed because the array write completes before IDLE.
- Write beats outside WCOL: o_wdat_rdy=0; input ignored.
- A new request is never accepted in the same cycle as the final beat or the ack; there is at least one IDLE cycle between bursts.
- o_busy = ~o_req_rdy.

Test Plan:
- Reset values: assert rst_n=0 with i_req_vld=1 -> o_req_rdy=1, o_rdat_vld=0, o_wr_ack=0, o_busy=0. After release, the request is accepted on the first edge.
- Full-line write then aligned read: write paddr=0x40, len=3, beats 0x..00..0x..03, all masks 0xFFFF -> o_wr_ack one cycle after the 4th beat. Read 0x40, len=3 -> 4 beats equal to the written ones, first beat 2 cycles after acceptance, o_rdat_last on beat 3.
- Masked partial write: write 0x80, len=0, mask 0x00FF, data all-ones, over a line preloaded with 0 -> reading 0x80 returns beat0 low 8 bytes 0xFF, all other bytes 0.
- Cross-line read: lines 1 and 2 preloaded with byte value = address LSB. Read paddr=0x70, len=1 -> RD1 visited; beat0 bytes 0x70..0x7F; beat1 bytes 0x80..0x8F; first beat 3 cycles after acceptance.
- Wrap plus backpressure: read paddr=0x3F0, len=3 (DEPTH=16) -> line 15 then line 0. Hold i_rdat_rdy=0 for 5 cycles on beat 1 -> o_rdat stays stable and no beat is dropped or duplicated.
- Reset mid-write: drop rst_n after 2 of 4 beats -> no o_wr_ack; a later read of that line returns the pre-write contents.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: collects write beats into a staged line and commits it
// to a line-wide array with byte masks; serves read bursts at any byte offset,
// fetching a second (wrapped) line when the burst crosses a line boundary.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_req_vld/o_req_rdy              request handshake (ready only when idle)
//   i_req_wr, i_req_paddr, i_req_len request type, byte address, beats-1
//   i_wdat_vld/o_wdat_rdy            write beat handshake (i_wdat, i_wmask)
//   o_wr_ack                         one-cycle line-commit pulse
//   o_rdat_vld/i_rdat_rdy            read beat handshake (o_rdat, o_rdat_last)
//   o_busy                           controller not idle
module mem_burst_ctrl #(
  parameter int unsigned BEAT_WIDTH  = 128,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_vld,
  output logic                     o_req_rdy,
  input  logic                     i_req_wr,
  input  logic [PADDR_WIDTH-1:0]   i_req_paddr,
  input  logic [$clog2(BEATS)-1:0] i_req_len,
  input  logic                     i_wdat_vld,
  output logic                     o_wdat_rdy,
  input  logic [BEAT_WIDTH-1:0]    i_wdat,
  input  logic [BEAT_WIDTH/8-1:0]  i_wmask,
  output logic                     o_wr_ack,
  output logic                     o_rdat_vld,
  input  logic                     i_rdat_rdy,
  output logic [BEAT_WIDTH-1:0]    o_rdat,
  output logic                     o_rdat_last,
  output logic                     o_busy
);

  localparam int unsigned BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int unsigned LINE_BYTES = BEATS * BEAT_BYTES;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned OFS_W      = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned LEN_W      = $clog2(BEATS);
  localparam int unsigned SUM_W      = OFS_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WCOL, S_WCOMMIT, S_RD0, S_RD1, S_RRESP
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [OFS_W-1:0]        ofs_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [LINE_BYTES-1:0]   stage_mask_q;
  logic [LINE_W-1:0]       stage_data_q;
  logic [LINE_W-1:0]       rd_q;
  logic [LINE_W-1:0]       line0_q;
  logic [LINE_W-1:0]       mem [DEPTH];

  logic                    wbeat_c, rbeat_c, cnt_last_c, cross_c;
  logic [SUM_W-1:0]        span_c;
  logic [2*LINE_W-1:0]     pair_c;
  logic [LINE_W-1:0]       win_c;
  logic [BEAT_WIDTH-1:0]   beat_c;
  logic                    unused_paddr;

  // Upper address bits alias onto the same lines.
  assign unused_paddr = ^i_req_paddr[PADDR_WIDTH-1:OFS_W+IDX_W];

  assign wbeat_c    = (state_q == S_WCOL) && i_wdat_vld;
  assign rbeat_c    = (state_q == S_RRESP) && i_rdat_rdy;
  assign cnt_last_c = (cnt_q == len_q);

  // Burst crosses into the next line when its last byte lies beyond this line.
  assign span_c  = SUM_W'(ofs_q) + (SUM_W'(len_q) + SUM_W'(1)) * SUM_W'(BEAT_BYTES);
  assign cross_c = (span_c > SUM_W'(LINE_BYTES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_req_vld) state_d = i_req_wr ? S_WCOL : S_RD0;
      S_WCOL:    if (i_wdat_vld && cnt_last_c) state_d = S_WCOMMIT;
      S_WCOMMIT: state_d = S_IDLE;
      S_RD0:     state_d = cross_c ? S_RD1 : S_RRESP;
      S_RD1:     state_d = S_RRESP;
      S_RRESP:   if (i_rdat_rdy && cnt_last_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request capture, beat counter and staging masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      ofs_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      stage_mask_q <= '0;
    end else if ((state_q == S_IDLE) && i_req_vld) begin
      idx_q <= i_req_paddr[OFS_W+IDX_W-1:OFS_W];
      ofs_q <= i_req_paddr[OFS_W-1:0];
      len_q <= i_req_len;
      cnt_q <= '0;
      if (i_req_wr) stage_mask_q <= '0;
    end else if (wbeat_c) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (cnt_q == LEN_W'(k)) stage_mask_q[k*BEAT_BYTES +: BEAT_BYTES] <= i_wmask;
      end
      cnt_q <= cnt_last_c ? '0 : cnt_q + LEN_W'(1);
    end else if (rbeat_c) begin
      cnt_q <= cnt_last_c ? '0 : cnt_q + LEN_W'(1);
    end
  end

  // Staging data; slots without a mask bit are never committed.
  always_ff @(posedge clk) begin
    if (wbeat_c) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (cnt_q == LEN_W'(k)) stage_data_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_wdat;
      end
    end
  end

  // Masked line commit.
  always_ff @(posedge clk) begin
    if (state_q == S_WCOMMIT) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (stage_mask_q[b]) mem[idx_q][b*8 +: 8] <= stage_data_q[b*8 +: 8];
      end
    end
  end

  // Synchronous line reads; RD1 parks the first line and fetches the wrapped next one.
  always_ff @(posedge clk) begin
    if (state_q == S_RD0) begin
      rd_q <= mem[idx_q];
    end else if (state_q == S_RD1) begin
      line0_q <= rd_q;
      rd_q    <= mem[idx_q + IDX_W'(1)];
    end
  end

  // Byte-aligned window over the fetched line pair, then beat select.
  assign pair_c = cross_c ? {rd_q, line0_q} : {{LINE_W{1'b0}}, rd_q};
  assign win_c  = LINE_W'(pair_c >> {ofs_q, 3'b000});

  always_comb begin
    beat_c = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (cnt_q == LEN_W'(k)) beat_c = win_c[k*BEAT_WIDTH +: BEAT_WIDTH];
    end
  end

  assign o_req_rdy   = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_wdat_rdy  = (state_q == S_WCOL);
  assign o_wr_ack    = (state_q == S_WCOMMIT);
  assign o_rdat_vld  = (state_q == S_RRESP);
  assign o_rdat      = o_rdat_vld ? beat_c : '0;
  assign o_rdat_last = o_rdat_vld && cnt_last_c;

endmodule
